// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory port arbiter.
//               FSM state encoding, port indices and byte-strobe width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic P_CORE = 1'b0;
    localparam logic P_DBG  = 1'b1;
    localparam int   BE_W   = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Bundle of both requester ports, the memory macro port and the
//               busy flag. "master" is the requester/memory side, "slave" is
//               the arbiter.
// Ports       : m0_* core LSU port, m1_* debug/DMA port, mem_* memory macro,
//               busy arbiter activity flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import dmem_arb_pkg::*;

    logic            m0_req;
    logic [BE_W-1:0] m0_be;
    logic [AW-1:0]   m0_addr;
    logic [DW-1:0]   m0_wdata;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [DW-1:0]   m0_rdata;

    logic            m1_req;
    logic [BE_W-1:0] m1_be;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_wdata;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [DW-1:0]   m1_rdata;

    logic            mem_en;
    logic [BE_W-1:0] mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic            busy;

    modport master (
        output m0_req, m0_be, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_be, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

    modport slave (
        input  m0_req, m0_be, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_be, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pick
// Description : Combinational winner selection between the two requesters.
//               Default: fixed priority to port 0, overridden for port 1 once
//               the starvation count reaches MAX_STARVE.
//               With DMEM_ARB_RR_EN defined: round-robin on last_winner.
// Ports       : i_req0/i_req1 requests, i_starve_cnt or i_last_winner,
//               o_any (some request pending), o_winner (port index).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_STARVE = 4,
    parameter int SCW        = 3
) (
    input  logic           i_req0,
    input  logic           i_req1,
`ifdef DMEM_ARB_RR_EN
    input  logic           i_last_winner,
`else
    input  logic [SCW-1:0] i_starve_cnt,
`endif
    output logic           o_any,
    output logic           o_winner
);

    assign o_any = i_req0 | i_req1;

`ifdef DMEM_ARB_RR_EN
    // On contention the port that did not win last time goes first.
    assign o_winner = (i_req0 & i_req1) ? ~i_last_winner : (i_req1 ? P_DBG : P_CORE);
`else
    logic w_force1;
    assign w_force1 = (i_starve_cnt == SCW'(MAX_STARVE));
    assign o_winner = (i_req1 & (~i_req0 | w_force1)) ? P_DBG : P_CORE;
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares a single-ported data memory between the core LSU
//               (port 0) and the debug/DMA master (port 1). Each access runs
//               IDLE(grant) -> ISSUE(mem_en) -> [WAIT x RD_LAT -> RESP] for
//               reads; writes return to IDLE straight after ISSUE.
// Ports       : clk, rst (asynchronous, active-high), bus (slave modport of
//               dmem_port_arbiter_if).
// Config      : DMEM_ARB_RR_EN selects round-robin arbitration instead of
//               fixed priority with starvation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);

    localparam int SCW = $clog2(MAX_STARVE + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;
    logic [BE_W-1:0] r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [2:0]      r_cnt;
    logic [DW-1:0]   r_rdata0;
    logic [DW-1:0]   r_rdata1;
    logic            w_any;
    logic            w_winner;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_grant;

    assign w_grant = (r_state == IDLE) && w_any;

`ifdef DMEM_ARB_RR_EN
    logic r_last_winner;

    dmem_arb_pick #(.MAX_STARVE(MAX_STARVE), .SCW(SCW)) u_pick (
        .i_req0        (bus.m0_req),
        .i_req1        (bus.m1_req),
        .i_last_winner (r_last_winner),
        .o_any         (w_any),
        .o_winner      (w_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_winner <= P_DBG;
        end else if (w_grant) begin
            r_last_winner <= w_winner;
        end
    end
`else
    logic [SCW-1:0] r_starve;

    dmem_arb_pick #(.MAX_STARVE(MAX_STARVE), .SCW(SCW)) u_pick (
        .i_req0       (bus.m0_req),
        .i_req1       (bus.m1_req),
        .i_starve_cnt (r_starve),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    // Counts port-0 wins taken while port 1 waits; only evaluated in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == IDLE) begin
            if (!bus.m1_req || w_winner == P_DBG) begin
                r_starve <= '0;
            end else if (r_starve != SCW'(MAX_STARVE)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ISSUE;
                    w_gnt0      = (w_winner == P_CORE);
                    w_gnt1      = (w_winner == P_DBG);
                end
            end
            ISSUE:   w_state_nxt = (r_be != '0) ? IDLE : WAIT;
            WAIT:    if (r_cnt == 3'd1) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The transaction runs from this registered copy so requesters may
    // change or drop their fields right after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= P_CORE;
            r_be     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_winner;
                r_be    <= (w_winner == P_DBG) ? bus.m1_be    : bus.m0_be;
                r_addr  <= (w_winner == P_DBG) ? bus.m1_addr  : bus.m0_addr;
                r_wdata <= (w_winner == P_DBG) ? bus.m1_wdata : bus.m0_wdata;
            end
            if (r_state == ISSUE) begin
                r_cnt <= 3'(RD_LAT);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
            // Memory data is valid in the last WAIT cycle.
            if (r_state == WAIT && r_cnt == 3'd1) begin
                if (r_owner == P_DBG) begin
                    r_rdata1 <= bus.mem_rdata;
                end else begin
                    r_rdata0 <= bus.mem_rdata;
                end
            end
        end
    end

    // Grants are combinational from IDLE, so mask them while reset is held.
    assign bus.m0_gnt    = w_gnt0 & ~rst;
    assign bus.m1_gnt    = w_gnt1 & ~rst;
    assign bus.m0_rvalid = (r_state == RESP) && (r_owner == P_CORE);
    assign bus.m1_rvalid = (r_state == RESP) && (r_owner == P_DBG);
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
    assign bus.mem_en    = (r_state == ISSUE);
    assign bus.mem_we    = (r_state == ISSUE) ? r_be : '0;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter. Instance A uses
//               RD_LAT=1, instance B uses RD_LAT=3. Read data expectations
//               come from a reference memory model queued at grant time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam logic [31:0] POISON = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter_if #(.AW(32), .DW(32)) bus_a ();
    dmem_port_arbiter_if #(.AW(32), .DW(32)) bus_b ();

    dmem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_STARVE(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    dmem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_STARVE(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 64)  return 32'hDEAD_BEEF;
        if (i == 129) return 32'h1122_3344;
        return 32'hC000_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    // ---------------- memory macro models ----------------
    logic [31:0] mem_a [0:255];
    logic        mem_a_init = 1'b0;
    logic [31:0] pipe_a = POISON;
    logic [31:0] pipe_b [0:2];

    always @(posedge clk) begin
        if (!mem_a_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
            mem_a_init <= 1'b1;
        end else if (bus_a.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus_a.mem_we[b])
                    mem_a[bus_a.mem_addr[9:2]][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
        end
        pipe_a <= (bus_a.mem_en && bus_a.mem_we == 4'd0) ? mem_a[bus_a.mem_addr[9:2]] : POISON;
        pipe_b[0] <= (bus_b.mem_en && bus_b.mem_we == 4'd0) ? init_word(int'(bus_b.mem_addr[9:2])) : POISON;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_a.mem_rdata = pipe_a;
    assign bus_b.mem_rdata = pipe_b[2];

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] ref_a [int];
    logic [31:0] exp_a0 [$];
    logic [31:0] exp_a1 [$];
    logic [31:0] exp_b0 [$];
    logic [31:0] exp_b1 [$];
    int          glog [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
        end
    endtask

    function automatic logic [31:0] ref_rd_a(input int idx);
        return ref_a.exists(idx) ? ref_a[idx] : init_word(idx);
    endfunction

    task automatic accept_a(input int port, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wd);
        int          idx;
        logic [31:0] w;
        idx = int'(addr[9:2]);
        w   = ref_rd_a(idx);
        if (be == 4'd0) begin
            if (port == 0) exp_a0.push_back(w);
            else           exp_a1.push_back(w);
        end else begin
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_a[idx] = w;
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.m0_gnt && bus_a.m1_gnt) begin
            glog.push_back(2);
        end else if (bus_a.m0_gnt) begin
            glog.push_back(0);
            accept_a(0, bus_a.m0_be, bus_a.m0_addr, bus_a.m0_wdata);
        end else if (bus_a.m1_gnt) begin
            glog.push_back(1);
            accept_a(1, bus_a.m1_be, bus_a.m1_addr, bus_a.m1_wdata);
        end
        if (bus_b.m0_gnt && bus_b.m0_be == 4'd0) exp_b0.push_back(init_word(int'(bus_b.m0_addr[9:2])));
        if (bus_b.m1_gnt && bus_b.m1_be == 4'd0) exp_b1.push_back(init_word(int'(bus_b.m1_addr[9:2])));

        if (bus_a.m0_rvalid) begin
            if (exp_a0.size() == 0) chk("a0_unexpected_rvalid", 32'd1, 32'd0);
            else                    chk("a0_rdata", bus_a.m0_rdata, exp_a0.pop_front());
        end
        if (bus_a.m1_rvalid) begin
            if (exp_a1.size() == 0) chk("a1_unexpected_rvalid", 32'd1, 32'd0);
            else                    chk("a1_rdata", bus_a.m1_rdata, exp_a1.pop_front());
        end
        if (bus_b.m0_rvalid) begin
            if (exp_b0.size() == 0) chk("b0_unexpected_rvalid", 32'd1, 32'd0);
            else                    chk("b0_rdata", bus_b.m0_rdata, exp_b0.pop_front());
        end
        if (bus_b.m1_rvalid) begin
            if (exp_b1.size() == 0) chk("b1_unexpected_rvalid", 32'd1, 32'd0);
            else                    chk("b1_rdata", bus_b.m1_rdata, exp_b1.pop_front());
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit on_b, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while ((on_b ? bus_b.busy : bus_a.busy) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(on_b ? bus_b.busy : bus_a.busy), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int exp_order [10];
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        bus_a.m0_req = 0; bus_a.m0_be = 0; bus_a.m0_addr = 0; bus_a.m0_wdata = 0;
        bus_a.m1_req = 0; bus_a.m1_be = 0; bus_a.m1_addr = 0; bus_a.m1_wdata = 0;
        bus_b.m0_req = 0; bus_b.m0_be = 0; bus_b.m0_addr = 0; bus_b.m0_wdata = 0;
        bus_b.m1_req = 0; bus_b.m1_be = 0; bus_b.m1_addr = 0; bus_b.m1_wdata = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_mem_en", 32'(bus_a.mem_en), 32'd0);
        chk("rst_mem_addr", bus_a.mem_addr, 32'd0);
        chk("rst_m0_rdata", bus_a.m0_rdata, 32'd0);
        chk("rst_rvalid", 32'({bus_a.m0_rvalid, bus_a.m1_rvalid}), 32'd0);
        nxt();
        rst = 1'b0;

        // Port 0 read of 0x100, RD_LAT=1
        bus_a.m0_req = 1; bus_a.m0_be = 4'b0000; bus_a.m0_addr = 32'h100;
        @(negedge clk);
        chk("t1_m0_gnt", 32'(bus_a.m0_gnt), 32'd1);
        chk("t1_m1_gnt", 32'(bus_a.m1_gnt), 32'd0);
        nxt(); bus_a.m0_req = 0;
        @(negedge clk);
        chk("t1_mem_en", 32'(bus_a.mem_en), 32'd1);
        chk("t1_mem_we", 32'(bus_a.mem_we), 32'd0);
        chk("t1_mem_addr", bus_a.mem_addr, 32'h100);
        nxt(); @(negedge clk);
        chk("t1_rvalid_t2", 32'(bus_a.m0_rvalid), 32'd0);
        nxt(); @(negedge clk);
        chk("t1_rvalid_t3", 32'(bus_a.m0_rvalid), 32'd1);
        chk("t1_m0_rdata", bus_a.m0_rdata, 32'hDEAD_BEEF);
        chk("t1_m1_rdata", bus_a.m1_rdata, 32'd0);
        nxt();

        // Port 1 partial write to 0x204
        bus_a.m1_req = 1; bus_a.m1_be = 4'b1100; bus_a.m1_addr = 32'h204; bus_a.m1_wdata = 32'hABCD_0000;
        @(negedge clk);
        chk("t2_m1_gnt", 32'(bus_a.m1_gnt), 32'd1);
        chk("t2_m0_gnt", 32'(bus_a.m0_gnt), 32'd0);
        nxt(); bus_a.m1_req = 0; bus_a.m1_be = 4'b0000; bus_a.m1_wdata = 32'h0;
        @(negedge clk);
        chk("t2_mem_en", 32'(bus_a.mem_en), 32'd1);
        chk("t2_mem_we", 32'(bus_a.mem_we), 32'b1100);
        chk("t2_mem_addr", bus_a.mem_addr, 32'h204);
        chk("t2_mem_wdata", bus_a.mem_wdata, 32'hABCD_0000);
        nxt(); @(negedge clk);
        chk("t2_busy_t2", 32'(bus_a.busy), 32'd0);
        chk("t2_no_rvalid", 32'(bus_a.m1_rvalid), 32'd0);

        // Port 1 reads back the merged word
        nxt(); bus_a.m1_req = 1; bus_a.m1_be = 4'b0000; bus_a.m1_addr = 32'h204;
        @(negedge clk);
        chk("t2r_m1_gnt", 32'(bus_a.m1_gnt), 32'd1);
        nxt(); bus_a.m1_req = 0;
        wait_idle(1'b0, "t2r_idle");
        chk("t2r_m1_rdata", bus_a.m1_rdata, 32'hABCD_3344);
        chk("t2r_m0_rdata_kept", bus_a.m0_rdata, 32'hDEAD_BEEF);

        // Continuous contention: grant order
        nxt();
        glog.delete();
        bus_a.m0_req = 1; bus_a.m0_be = 0; bus_a.m0_addr = 32'h10;
        bus_a.m1_req = 1; bus_a.m1_be = 0; bus_a.m1_addr = 32'h20;
        for (int k = 0; k < 100 && glog.size() < 10; k++) @(negedge clk);
        nxt(); bus_a.m0_req = 0; bus_a.m1_req = 0;
        chk("t3_grant_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t3_order%0d", i), 32'((i < glog.size()) ? glog[i] : 9), 32'(exp_order[i]));
        wait_idle(1'b0, "t3_idle");

        // RD_LAT=3: rvalid at T+5, port 1 raised at T+1 granted at T+6
        nxt(); bus_b.m0_req = 1; bus_b.m0_be = 0; bus_b.m0_addr = 32'h40;
        @(negedge clk);
        chk("t4_m0_gnt", 32'(bus_b.m0_gnt), 32'd1);
        nxt(); bus_b.m0_req = 0; bus_b.m1_req = 1; bus_b.m1_be = 0; bus_b.m1_addr = 32'h44;
        @(negedge clk);
        chk("t4_m1_gnt_t1", 32'(bus_b.m1_gnt), 32'd0);
        for (int k = 2; k <= 6; k++) begin
            nxt(); @(negedge clk);
            chk($sformatf("t4_rvalid_t%0d", k), 32'(bus_b.m0_rvalid), 32'(k == 5));
            chk($sformatf("t4_m1_gnt_t%0d", k), 32'(bus_b.m1_gnt), 32'(k == 6));
        end
        nxt(); bus_b.m1_req = 0;
        wait_idle(1'b1, "t4_idle");

        // Reset during WAIT of a port-1 read
        nxt(); bus_a.m1_req = 1; bus_a.m1_be = 0; bus_a.m1_addr = 32'h30;
        @(negedge clk);
        chk("t5_m1_gnt", 32'(bus_a.m1_gnt), 32'd1);
        nxt(); bus_a.m1_req = 0;
        nxt(); @(negedge clk);
        chk("t5_busy_wait", 32'(bus_a.busy), 32'd1);
        #2;
        rst = 1'b1;
        bus_a.m0_req = 1; bus_a.m0_addr = 32'h60;
        bus_a.m1_req = 1; bus_a.m1_addr = 32'h64;
        #1;
        chk("t5_rst_busy", 32'(bus_a.busy), 32'd0);
        chk("t5_rst_gnt", 32'({bus_a.m0_gnt, bus_a.m1_gnt}), 32'd0);
        chk("t5_rst_rvalid", 32'({bus_a.m0_rvalid, bus_a.m1_rvalid}), 32'd0);
        chk("t5_rst_mem", 32'({bus_a.mem_en, bus_a.mem_we}), 32'd0);
        chk("t5_rst_mem_addr", bus_a.mem_addr, 32'd0);
        chk("t5_rst_m1_rdata", bus_a.m1_rdata, 32'd0);
        chk("t5_pending", 32'(exp_a1.size()), 32'd1);
        exp_a1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_m0_gnt", 32'(bus_a.m0_gnt), 32'd1);
        chk("t5_post_m1_gnt", 32'(bus_a.m1_gnt), 32'd0);
        nxt(); bus_a.m0_req = 0; bus_a.m1_req = 0;
        wait_idle(1'b0, "t5_idle");

        // Fields change right after grant
        nxt(); bus_a.m0_req = 1; bus_a.m0_be = 0; bus_a.m0_addr = 32'h50;
        @(negedge clk);
        chk("t6_m0_gnt", 32'(bus_a.m0_gnt), 32'd1);
        nxt(); bus_a.m0_req = 0; bus_a.m0_addr = 32'h99C;
        @(negedge clk);
        chk("t6_mem_en", 32'(bus_a.mem_en), 32'd1);
        chk("t6_mem_addr", bus_a.mem_addr, 32'h50);
        wait_idle(1'b0, "t6_idle");

        repeat (3) @(negedge clk);
        chk("end_q_a0", 32'(exp_a0.size()), 32'd0);
        chk("end_q_a1", 32'(exp_a1.size()), 32'd0);
        chk("end_q_b0", 32'(exp_b0.size()), 32'd0);
        chk("end_q_b1", 32'(exp_b1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between two requesters: port 0, the core load/store unit, and port 1, the debug/DMA master.
- Sequences each access through an issue phase and a read-latency wait. Returns read data to the owning port with a valid pulse.
- Sits between the requesters' byte-lane-aligned outputs (address, 4-bit byte strobe, shifted write data) and the data memory macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32 with 4 byte strobes.
- RD_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..7.
- MAX_STARVE, 4, consecutive port-0 grants allowed while port 1 is waiting before port 1 is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m0_req  in  1  port 0 request; held with its fields until m0_gnt
- m0_be  in  4  byte strobes; nonzero=write, 0=read
- m0_addr  in  AW  address
- m0_wdata  in  DW  write data, already lane-shifted
- m0_gnt  out  1  one-cycle accept pulse
- m0_rvalid  out  1  one-cycle read-data valid
- m0_rdata  out  DW  read data, held until the next port-0 read response
- m1_req, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1
- mem_en  out  1  memory access strobe
- mem_we  out  4  memory byte write enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: asynchronous and active-high. All outputs go to 0, the FSM goes to IDLE, the starvation counter clears and last_winner=1. Reset asserted mid-transaction aborts it with no gnt, rvalid or mem_en afterwards.
- FSM states:
  - IDLE: if any req is high, pick a winner, pulse its gnt, register its be/addr/wdata and owner, then go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): mem_en=1; mem_we/mem_addr/mem_wdata come from the registered fields. If the access is a write, go to IDLE. If a read, load cnt=RD_LAT and go to WAIT.
  - WAIT: decrement cnt. When cnt==1, register mem_rdata into the owner's rdata register and go to RESP.
  - RESP (1 cycle): owner rvalid=1, then go to IDLE.
- mem_en and mem_we are 0 outside ISSUE. mem_addr and mem_wdata hold their last values.
- Timing, with gnt at cycle T:
  - mem_en at T+1.
  - Memory drives data during T+1+RD_LAT.
  - rvalid at T+2+RD_LAT.
  - Minimum gnt spacing: write 2 cycles, read RD_LAT+3 cycles.
- Grants are issued only in IDLE.
- A req dropped before gnt is legal; no access occurs.
- After gnt, the requester may change its fields or drop req. The transaction completes from the registered copy.
- Default arbitration is fixed priority, with port 0 winning.
- Starvation counter:
  - Increments when port 0 wins while m1_req=1.
  - Clears when port 1 wins or m1_req=0 in IDLE.
  - When count==MAX_STARVE and m1_req=1, port 1 wins regardless of m0_req.
  - The counter saturates at MAX_STARVE.
- Simultaneous reqs in IDLE produce exactly one gnt. The loser keeps its req and is evaluated again at the next IDLE.
- The non-owner's rdata register is never modified.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- When defined: round-robin arbitration. On contention the port not equal to last_winner wins. last_winner updates on every grant. The starvation counter and MAX_STARVE are unused and removed.
- When undefined: fixed priority with the starvation counter, as specified in Behaviour.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, RESP);
  - the port index constants P_CORE=0 and P_DBG=1;
  - the byte-strobe width constant BE_W=4.
- One sub-module, dmem_arb_pick: combinational winner selection from the two reqs, last_winner and the starvation count. It contains the DMEM_ARB_RR_EN switch. The FSM, registers and counters stay in the top level.

Test Plan:
- Port 0 read, addr 0x100, RD_LAT=1, memory returns 0xDEADBEEF -> m0_gnt at T, mem_en with mem_we=0 at T+1, m0_rvalid at T+3 with m0_rdata=0xDEADBEEF, m1_rdata unchanged.
- Port 1 write, be=4'b1100, wdata=0xABCD0000, addr 0x204 -> mem_en at T+1 with mem_we=1100 and mem_addr=0x204, no rvalid, busy low at T+2.
- Both ports requesting reads continuously, MAX_STARVE=4, macro undefined -> grant order 0,0,0,0,1,0,0,0,0,1. With DMEM_ARB_RR_EN defined -> order 0,1,0,1.
- RD_LAT=3, port 0 read -> rvalid exactly at T+5. A port 1 req raised at T+1 -> m1_gnt at T+6, not earlier.
- rst asserted during WAIT of a port-1 read -> all outputs 0 immediately. No m1_rvalid after release. Next grant goes to port 0 when both ports request.
- Port 0 drops req and changes addr in the cycle after gnt -> mem_addr still shows the original granted address in ISSUE.
